// File: rtl/dff_bank_arbiter.sv
// Round-robin owner of a shared WIDTH-bit capture register: grants one requester,
// captures its data lane, bounds the hold time and blocks a timed-out requester.
module dff_bank_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*WIDTH-1:0]    wdata,
  output logic [N_REQ-1:0]          gnt,
  output logic [WIDTH-1:0]          q,
  output logic                      q_valid,
  output logic [$clog2(N_REQ)-1:0]  owner,
  output logic                      busy,
  output logic                      timeout
);

  localparam int OW = $clog2(N_REQ);
  localparam logic [OW-1:0]    LAST_RST = OW'(N_REQ - 1);
  localparam logic [7:0]       HOLD_LIM = 8'(HOLD_MAX);
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [N_REQ-1:0]  gnt_r, gnt_s;
  logic [N_REQ-1:0]  blocked_r, blocked_s, blocked_set_s;
  logic [WIDTH-1:0]  q_r, q_s;
  logic              q_valid_r, q_valid_s;
  logic              timeout_r, timeout_s;
  logic              busy_r, busy_s;
  logic [OW-1:0]     owner_r, owner_s;
  logic [OW-1:0]     last_r, last_s;
  logic [7:0]        cnt_r, cnt_s;
  logic [OW:0]       pick_s;
  logic [WIDTH-1:0]  lane_s [N_REQ];

  // Nearest eligible index after 'last', wrapping; MSB of the result flags a hit.
  function automatic logic [OW:0] rr_pick(input logic [N_REQ-1:0] elig,
                                          input logic [OW-1:0]    last);
    logic [OW:0]   res;
    logic [OW-1:0] idx;
    res = {(OW+1){1'b0}};
    for (int k = N_REQ; k >= 1; k--) begin
      idx = OW'((int'(last) + k) % N_REQ);
      if (elig[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign lane_s[i] = wdata[i*WIDTH +: WIDTH];
  end

  assign pick_s = rr_pick(req & ~blocked_r, last_r);

  // Next-state and next-output decode for the grant sequencer.
  always_comb begin
    state_s       = state_r;
    gnt_s         = gnt_r;
    q_s           = q_r;
    q_valid_s     = 1'b0;
    timeout_s     = 1'b0;
    owner_s       = owner_r;
    last_s        = last_r;
    cnt_s         = cnt_r;
    blocked_set_s = {N_REQ{1'b0}};
    case (state_r)
      IDLE: begin
        gnt_s = {N_REQ{1'b0}};
        if (ena && pick_s[OW]) begin
          state_s = GRANT;
          gnt_s   = ONE_HOT0 << pick_s[OW-1:0];
          owner_s = pick_s[OW-1:0];
          last_s  = pick_s[OW-1:0];
        end else begin
          state_s = IDLE;
        end
      end
      GRANT: begin
        q_s       = lane_s[owner_r];
        q_valid_s = 1'b1;
        cnt_s     = 8'd0;
        state_s   = HOLD;
      end
      HOLD: begin
        if (!req[owner_r]) begin
          gnt_s   = {N_REQ{1'b0}};
          state_s = IDLE;
        end else if (cnt_r == HOLD_LIM) begin
          // Forced release; the owner sits out until it drops its request once.
          gnt_s                  = {N_REQ{1'b0}};
          timeout_s              = 1'b1;
          blocked_set_s[owner_r] = 1'b1;
          state_s                = IDLE;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      default: begin
        gnt_s   = {N_REQ{1'b0}};
        state_s = IDLE;
      end
    endcase
    blocked_s = (blocked_r & req) | blocked_set_s;
    busy_s    = (state_s != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      gnt_r     <= {N_REQ{1'b0}};
      blocked_r <= {N_REQ{1'b0}};
      q_r       <= {WIDTH{1'b0}};
      q_valid_r <= 1'b0;
      timeout_r <= 1'b0;
      busy_r    <= 1'b0;
      owner_r   <= {OW{1'b0}};
      last_r    <= LAST_RST;
      cnt_r     <= 8'd0;
    end else begin
      state_r   <= state_s;
      gnt_r     <= gnt_s;
      blocked_r <= blocked_s;
      q_r       <= q_s;
      q_valid_r <= q_valid_s;
      timeout_r <= timeout_s;
      busy_r    <= busy_s;
      owner_r   <= owner_s;
      last_r    <= last_s;
      cnt_r     <= cnt_s;
    end
  end

  assign gnt     = gnt_r;
  assign q       = q_r;
  assign q_valid = q_valid_r;
  assign timeout = timeout_r;
  assign busy    = busy_r;
  assign owner   = owner_r;

endmodule
